// File: rtl/audio_play_engine.sv
// audio_play_engine: plays a memory range [START_ADDR, select) to the DAC through a prefetch FIFO
module audio_play_engine #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_play_start,
    input  logic [ADDR_W-1:0] i_play_select,
    input  logic              i_play_pause,
    input  logic              i_play_stop,
    output logic              o_play_done,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_read,
    input  logic              i_mem_waitrequest,
    input  logic [15:0]       i_mem_readdata,
    input  logic              i_mem_readdatavalid,
    output logic [15:0]       o_sample,
    output logic              o_sample_valid,
    input  logic              i_sample_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            r_state, w_next;
    logic              r_start_d, r_outstanding, r_stall;
    logic [ADDR_W-1:0] r_end_addr, r_rd_addr;
    logic [15:0]       r_fifo [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [PW:0]       r_count;
    logic              w_start_edge, w_run, w_more, w_empty, w_accept, w_push, w_pop, w_flush;

    assign w_start_edge = i_play_start & ~r_start_d;
    assign w_run        = r_state == RUN;
    assign w_more       = r_rd_addr < r_end_addr;
    assign w_empty      = r_count == '0;
    assign w_accept     = o_mem_read & ~i_mem_waitrequest;
    assign w_push       = w_run & ~i_play_stop & r_outstanding & i_mem_readdatavalid;
    assign w_pop        = o_sample_valid & i_sample_ready;
    assign w_flush      = w_run & i_play_stop;

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;

    // next state: stop beats completion; a response arriving with stop needs no drain
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_edge) w_next = RUN;
            RUN: begin
                if (i_play_stop) w_next = (r_outstanding & ~i_mem_readdatavalid) ? DRAIN : DONE;
                else if (!w_more && !r_outstanding && w_empty) w_next = DONE;
            end
            DRAIN:   if (i_mem_readdatavalid) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // outputs: a stalled request is held through pause, withdrawn only by stop
    always_comb begin
        o_busy         = w_run | (r_state == DRAIN);
        o_play_done    = r_state == DONE;
        o_mem_read     = w_run & ~i_play_stop & (r_stall | (w_more & ~r_outstanding & ~r_count[PW] & ~i_play_pause));
        o_mem_addr     = r_rd_addr;
        o_sample_valid = w_run & ~i_play_stop & ~i_play_pause & ~w_empty;
        o_sample       = w_empty ? '0 : r_fifo[r_rptr];
    end

    // start edge detect, playback range and read handshake tracking
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_start_d     <= 1'b0;
            r_end_addr    <= '0;
            r_rd_addr     <= '0;
            r_outstanding <= 1'b0;
            r_stall       <= 1'b0;
        end else begin
            r_start_d <= i_play_start;
            r_stall   <= o_mem_read & i_mem_waitrequest;
            if (r_state == IDLE && w_start_edge) begin
                r_end_addr <= i_play_select;
                r_rd_addr  <= START_ADDR;
            end else if (w_accept) r_rd_addr <= r_rd_addr + ADDR_W'(1);
            if (w_accept) r_outstanding <= 1'b1;
            else if (i_mem_readdatavalid) r_outstanding <= 1'b0;
        end

    // FIFO pointers and occupancy; stop empties it at once
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end

    // FIFO sample storage
    always_ff @(posedge i_clk)
        if (w_push) r_fifo[r_wptr] <= i_mem_readdata;
endmodule

// File: tb/tb_audio_play_engine.sv
// tb_audio_play_engine: scoreboard bench with a behavioural memory and DAC environment
module tb_audio_play_engine;
    localparam int AW    = 23;
    localparam int DEPTH = 4;
    localparam int START = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          play_start, pause, stop, done, busy;
    logic [AW-1:0] play_select, mem_addr;
    logic          mem_read, mem_wait, mem_rdv, sample_valid, sample_ready;
    logic [15:0]   mem_rdata, sample;

    always #5 clk = ~clk;

    audio_play_engine #(.ADDR_W(AW), .START_ADDR(AW'(START)), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_play_start(play_start), .i_play_select(play_select),
        .i_play_pause(pause), .i_play_stop(stop), .o_play_done(done), .o_busy(busy),
        .o_mem_addr(mem_addr), .o_mem_read(mem_read), .i_mem_waitrequest(mem_wait),
        .i_mem_readdata(mem_rdata), .i_mem_readdatavalid(mem_rdv), .o_sample(sample),
        .o_sample_valid(sample_valid), .i_sample_ready(sample_ready)
    );

    int          checks = 0, errors = 0;
    logic [15:0] mem [64];
    logic [15:0] exp_q [$];
    int          addr_q [$];
    int          done_seen = 0, done_exp = 0, reads = 0, rdvs = 0, cnt = 0;
    int          lat = 1, ready_mode = 1, pause_mode = 0;
    bit          rand_wait = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, expected none", nm, act);
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // reference model: a playback of [START, sel) yields those addresses and words in order
    task automatic start_play(input int sel);
        for (int a = START; a < sel; a++) begin
            exp_q.push_back(mem[a]);
            addr_q.push_back(a);
        end
        done_exp++;
        play_select = AW'(sel);
        play_start  = 1'b1;
        cycle(1);
        play_start  = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done_seen < done_exp && n < 3000) begin
            cycle(1);
            n++;
        end
        check({nm, "_done"}, done_seen, done_exp);
        check({nm, "_samples_left"}, exp_q.size(), 0);
        check({nm, "_reads_left"}, addr_q.size(), 0);
        cycle(1);
        check({nm, "_busy_after"}, busy, 0);
    endtask

    task automatic set_modes(input int rm, input int pm, input int l, input bit rw);
        ready_mode = rm;
        pause_mode = pm;
        lat        = l;
        rand_wait  = rw;
        cycle(2);
    endtask

    // memory responder: one response per accepted read after lat cycles
    initial begin
        bit acc, stall_prev;
        int a, pend;
        mem_wait = 1'b0; mem_rdv = 1'b0; mem_rdata = '0; stall_prev = 1'b0; pend = 0;
        forever begin
            @(negedge clk);
            acc = rst_n && mem_read && !mem_wait;
            a   = int'(mem_addr);
            if (acc) begin
                reads++;
                if (pause && !stall_prev) fail("read_during_pause", a);
                if (addr_q.size() == 0) fail("unexpected_read", a);
                else check("rd_addr", a, addr_q.pop_front());
            end
            stall_prev = rst_n && mem_read && mem_wait;
            @(posedge clk);
            #1;
            mem_rdv = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rdv   = 1'b1;
                    mem_rdata = mem[pend & 63];
                    rdvs++;
                end
            end
            if (acc) begin
                pend = a;
                cnt  = lat;
            end
            mem_wait = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    // DAC ready and pause environment
    initial begin
        sample_ready = 1'b0;
        pause = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sample_ready = ready_mode == 2 ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
            pause        = pause_mode == 2 ? ($urandom_range(0, 5) == 0) : (pause_mode == 1);
        end
    end

    // monitor: pops the scoreboard on every DAC transfer
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (pause || stop) check("valid_blocked", sample_valid, 0);
            if (done) begin
                done_seen++;
                check("busy_at_done", busy, 0);
            end
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) fail("unexpected_sample", sample);
                else check("sample", sample, exp_q.pop_front());
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at 600000, expected to have finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, rv, d0, n;
        play_start = 1'b0; play_select = '0; stop = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        cycle(3);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_read", mem_read, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_sample", sample, 0);
        rst_n = 1'b1;
        cycle(2);

        set_modes(1, 0, 1, 1'b0);
        r0 = reads;
        start_play(4);
        wait_done("normal");
        check("normal_reads", reads - r0, 4);

        set_modes(0, 0, 2, 1'b0);
        r0 = reads;
        start_play(16);
        cycle(30);
        check("bp_reads", reads - r0, DEPTH);
        check("bp_valid", sample_valid, 1);
        check("bp_head", sample, 16'h1000);
        ready_mode = 1;
        wait_done("bp");
        check("bp_total_reads", reads - r0, 16);

        set_modes(1, 0, 4, 1'b0);
        rv = rdvs;
        start_play(12);
        n = 0;
        while (!(cnt >= 3 && rdvs - rv >= 2) && n < 500) begin cycle(1); n++; end
        check("pause_setup", n < 500, 1);
        pause_mode = 1;
        cycle(1);
        r0 = reads;
        rv = rdvs;
        cycle(20);
        check("pause_no_reads", reads - r0, 0);
        check("pause_read_completed", rdvs - rv, 1);
        check("pause_valid", sample_valid, 0);
        pause_mode = 0;
        wait_done("pause");

        set_modes(1, 0, 6, 1'b0);
        start_play(16);
        n = 0;
        while (!(cnt >= 4 && reads > 2) && n < 500) begin cycle(1); n++; end
        check("stop_setup", n < 500, 1);
        stop = 1'b1;
        exp_q.delete();
        addr_q.delete();
        rv = rdvs; d0 = done_seen; r0 = reads;
        @(negedge clk);
        check("stop_valid", sample_valid, 0);
        check("stop_busy", busy, 1);
        check("stop_read", mem_read, 0);
        n = 0;
        while (rdvs == rv && n < 50) begin @(negedge clk); n++; end
        check("drain_no_early_done", done_seen, d0);
        check("drain_busy", busy, 1);
        @(posedge clk);
        #1;
        wait_done("stop");
        stop = 1'b0;
        cycle(10);
        check("stop_no_more_reads", reads - r0, 0);

        set_modes(1, 0, 1, 1'b0);
        r0 = reads; d0 = done_seen;
        play_select = '0;
        play_start  = 1'b1;
        done_exp++;
        @(negedge clk);
        check("empty_n0_done", done, 0);
        @(negedge clk);
        check("empty_n1_busy", busy, 1);
        check("empty_n1_done", done, 0);
        @(negedge clk);
        check("empty_n2_done", done, 1);
        @(posedge clk);
        #1;
        cycle(100);
        play_start = 1'b0;
        check("empty_single_done", done_seen - d0, 1);
        check("empty_no_reads", reads - r0, 0);
        cycle(3);
        start_play(4);
        wait_done("restart");

        set_modes(0, 0, 5, 1'b0);
        rv = rdvs;
        start_play(16);
        n = 0;
        while (!(rdvs - rv >= 3 && cnt > 0) && n < 500) begin cycle(1); n++; end
        check("rst_mid_setup", n < 500, 1);
        check("rst_mid_valid_before", sample_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_read", mem_read, 0);
        check("rst_mid_valid", sample_valid, 0);
        check("rst_mid_sample", sample, 0);
        check("rst_mid_done", done, 0);
        exp_q.delete();
        addr_q.delete();
        done_exp--;
        d0 = done_seen;
        cycle(1);
        rst_n = 1'b1;
        cycle(12);
        check("rst_mid_no_done", done_seen - d0, 0);
        check("rst_mid_idle_busy", busy, 0);
        check("rst_mid_idle_valid", sample_valid, 0);
        check("rst_mid_idle_read", mem_read, 0);

        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        for (int it = 0; it < 6; it++) begin
            int sel;
            sel = $urandom_range(0, 20);
            set_modes(2, (it % 2 == 1) ? 2 : 0, $urandom_range(1, 4), 1'b1);
            r0 = reads;
            start_play(sel);
            wait_done("random");
            check("random_reads", reads - r0, sel > START ? sel - START : 0);
        end
        set_modes(1, 0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_play_engine.md
Name: audio_play_engine

Overview:
- Responder side of the control core's play command interface.
- Consumes play_start, play_select, play_pause and play_stop, and returns play_done.
- Streams 16-bit samples from external memory through a small prefetch FIFO to the audio DAC path, using a valid/ready handshake.
- Sits between the control core, the memory arbiter (Avalon-style read master) and the DAC serializer.

Parameters:
- START_ADDR, 0, first word address of every playback.
- FIFO_DEPTH, 4, sample prefetch FIFO entries; power of two, minimum 2.
- ADDR_W, 23, memory word address width; matches the play_select width.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_play_start  in  1  level; a playback begins on its 0->1 edge
- i_play_select  in  ADDR_W  end address, exclusive; playback range is [START_ADDR, i_play_select)
- i_play_pause  in  1  level; hold playback while high
- i_play_stop  in  1  level; abort playback
- o_play_done  out  1  one-cycle pulse when playback completes or aborts
- o_busy  out  1  high from the accepted start edge until o_play_done
- o_mem_addr  out  ADDR_W  read address
- o_mem_read  out  1  read request
- i_mem_waitrequest  in  1  request stalled while high
- i_mem_readdata  in  16  read data
- i_mem_readdatavalid  in  1  read data strobe
- o_sample  out  16  FIFO head sample
- o_sample_valid  out  1  sample available
- i_sample_ready  in  1  DAC accepts a sample; transfer occurs when valid and ready are both high

Behaviour:
- Reset: async assert on i_rst_n=0. All outputs go to 0, FIFO empty, state IDLE, start-edge register cleared.
- Start detection:
  - A registered copy of i_play_start detects the rising edge.
  - The edge is honoured only in IDLE; edges while busy are ignored.
  - Holding start high does not retrigger.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start edge:
  - Latch end_addr <= i_play_select and rd_addr <= START_ADDR.
  - o_busy=1 from the next cycle.
  - If the edge is sampled in cycle N, o_mem_read may first assert in cycle N+1.
- RUN, reads:
  - At most one read outstanding.
  - Issue o_mem_read with o_mem_addr=rd_addr when all hold: rd_addr < end_addr, no read outstanding, fifo_count < FIFO_DEPTH, pause low.
  - o_mem_read and o_mem_addr stay stable while i_mem_waitrequest=1.
  - On acceptance (read & !waitrequest): rd_addr increments and the outstanding flag sets.
  - i_mem_readdatavalid pushes i_mem_readdata into the FIFO and clears the outstanding flag. The read slot is reserved, so this push can never overflow.
- RUN, output:
  - o_sample_valid = FIFO non-empty & !pause; o_sample = FIFO head.
  - Pop on valid & ready.
  - Simultaneous push and pop in one cycle keeps fifo_count unchanged.
- Pause (RUN, pause=1):
  - No new reads; o_sample_valid=0.
  - An already-accepted read still completes into the FIFO.
  - Resume on pause=0 with no sample lost or duplicated.
- Completion: RUN -> DONE when rd_addr == end_addr, no read outstanding and FIFO empty.
- Empty range: if end_addr <= START_ADDR, RUN -> DONE immediately with no memory reads issued.
- Stop in RUN (highest priority over pause):
  - Flush the FIFO; o_sample_valid=0 in the same cycle.
  - Read outstanding -> DRAIN. No read outstanding -> DONE.
  - A request stalled by waitrequest is withdrawn (o_mem_read=0).
- DRAIN: wait for i_mem_readdatavalid, discard the data, -> DONE.
- DONE: o_play_done=1 for exactly one cycle, o_busy=0 in that cycle, -> IDLE.
- Address arithmetic:
  - Unsigned ADDR_W bits, compared unsigned.
  - rd_addr never exceeds end_addr, so there is no wrap-around.
- Reset mid-operation: immediate return to IDLE. An in-flight memory response after reset is ignored, because the outstanding flag was cleared.

Test Plan:
- Normal playback:
  - Stimulus: START_ADDR=0, select=4, memory latency 2 cycles returning 0x1000..0x1003, ready=1.
  - Response: exactly 4 reads at addresses 0..3; samples 0x1000..0x1003 in order; one o_play_done pulse; o_busy low afterwards.
- Backpressure:
  - Stimulus: select=16, ready=0.
  - Response: reads stop after 4 accepted; no overflow; valid held with o_sample=first word. Then ready=1 yields all 16 samples in order, then done.
- Pause:
  - Stimulus: assert pause with one read outstanding; hold 20 cycles.
  - Response: read completes into the FIFO; no new reads; valid=0. On release, the sample stream continues with no gap or duplicate values.
- Stop with read outstanding:
  - Stimulus: stop asserted mid-read, response delayed 5 cycles.
  - Response: FIFO flushed; state DRAIN; late data not output; single done pulse after readdatavalid; no further reads.
- Edges and empty range:
  - Stimulus: start held high for 100 cycles with select=0.
  - Response: zero reads; one done pulse 2 cycles after the edge; no retrigger. A second edge after start falls starts a new playback.
- Reset mid-operation:
  - Stimulus: i_rst_n=0 during RUN with FIFO at 3 entries.
  - Response: all outputs 0 immediately; after release the block is IDLE; a stale readdatavalid is ignored; no done pulse.
